// File: rtl/compare_seq_ctrl.sv
// compare_seq_ctrl: nibble-serial unsigned magnitude comparator built around one shared 4-bit slice.
// Define COMPARE_SEQ_EARLY_EXIT_EN to finish at the first unequal nibble (variable latency 1..N).

module compare_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lt_c,
  output logic       eq_c,
  output logic       gt_c
);
  always_comb begin
    lt_c = (a < b);
    eq_c = (a == b);
    gt_c = (a > b);
  end
endmodule

module compare_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);
  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] a_reg, a_reg_n;
  logic [WIDTH-1:0] b_reg, b_reg_n;
  logic             lt_n, eq_n, gt_n;
  logic             busy_n, done_n;
  logic [3:0]       nib_a, nib_b;
  logic             s_lt, s_eq, s_gt;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
  logic             sticky_lt, sticky_lt_n;
  logic             sticky_gt, sticky_gt_n;
`endif

  // Select the nibble under examination, MSB first.
  assign nib_a = 4'(a_reg >> {idx, 2'b00});
  assign nib_b = 4'(b_reg >> {idx, 2'b00});

  compare_4bit u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .lt_c (s_lt),
    .eq_c (s_eq),
    .gt_c (s_gt)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    a_reg_n = a_reg;
    b_reg_n = b_reg;
    lt_n    = lt;
    eq_n    = eq;
    gt_n    = gt;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
    sticky_lt_n = sticky_lt;
    sticky_gt_n = sticky_gt;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          a_reg_n = a;
          b_reg_n = b;
          idx_n   = IDX_W'(N - 1);
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
          sticky_lt_n = 1'b0;
          sticky_gt_n = 1'b0;
`endif
          state_n = S_RUN;
        end
      end
      S_RUN: begin
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
        if (s_lt || s_gt) begin
          lt_n    = s_lt;
          eq_n    = 1'b0;
          gt_n    = s_gt;
          state_n = S_DONE;
        end else if (s_eq && (idx == '0)) begin
          lt_n    = 1'b0;
          eq_n    = 1'b1;
          gt_n    = 1'b0;
          state_n = S_DONE;
        end else begin
          idx_n = idx - IDX_W'(1);
        end
`else
        // First unequal nibble wins; later nibbles cannot override it.
        if (!sticky_lt && !sticky_gt) begin
          sticky_lt_n = s_lt;
          sticky_gt_n = s_gt;
        end
        if (idx == '0) begin
          lt_n    = sticky_lt_n;
          eq_n    = s_eq && !sticky_lt && !sticky_gt;
          gt_n    = sticky_gt_n;
          state_n = S_DONE;
        end else begin
          idx_n = idx - IDX_W'(1);
        end
`endif
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
      sticky_lt <= 1'b0;
      sticky_gt <= 1'b0;
`endif
    end else begin
      state <= state_n;
      idx   <= idx_n;
      a_reg <= a_reg_n;
      b_reg <= b_reg_n;
      busy  <= busy_n;
      done  <= done_n;
      lt    <= lt_n;
      eq    <= eq_n;
      gt    <= gt_n;
`ifndef COMPARE_SEQ_EARLY_EXIT_EN
      sticky_lt <= sticky_lt_n;
      sticky_gt <= sticky_gt_n;
`endif
    end
  end
endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Bench for compare_seq_ctrl: cycle-accurate scoreboard model for the 16-bit instance, hand sequences for WIDTH=4.
// Honours COMPARE_SEQ_EARLY_EXIT_EN the same way the design does.

module tb_compare_seq_ctrl;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, lt, eq, gt;
  logic        start4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, lt4, eq4, gt4;

  compare_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  compare_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gt(gt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        lt;
    logic        eq;
    logic        gt;
  } vec_t;

  typedef struct {
    logic lt;
    logic eq;
    logic gt;
    int   done_cyc;
  } sb_t;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   busy_until = -1;
  logic mon_en   = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  logic m_lt = 1'b0, m_eq = 1'b0, m_gt = 1'b0;
  sb_t  sb[$];

  function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y);
    return {x < y, x == y, x > y};
  endfunction

  function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
    logic [15:0] sx, sy;
    for (int i = N - 1; i >= 0; i--) begin
      sx = x >> (4 * i);
      sy = y >> (4 * i);
      if (sx[3:0] != sy[3:0]) return N - i;
    end
    return N;
`else
    if (x == y) return N;
    return N;
`endif
  endfunction

  // Reference model: tracks acceptance, expected busy window, done cycle and held results.
  always @(posedge clk) begin
    logic [2:0] r;
    int         j;
    sb_t        e;
    cyc = cyc + 1;
    if (rst) begin
      sb.delete();
      busy_until = -1;
      m_lt = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
      exp_done = 1'b0;
    end else begin
      if ((cyc - 1 > busy_until) && start) begin
        r = ref_cmp(a, b);
        j = ref_lat(a, b);
        e.lt = r[2]; e.eq = r[1]; e.gt = r[0];
        e.done_cyc = cyc + j;
        sb.push_back(e);
        busy_until = cyc + j;
      end
      exp_done = 1'b0;
      if (sb.size() > 0 && sb[0].done_cyc == cyc) begin
        exp_done = 1'b1;
        m_lt = sb[0].lt; m_eq = sb[0].eq; m_gt = sb[0].gt;
        void'(sb.pop_front());
      end
    end
    exp_busy = (cyc <= busy_until);
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got {busy,done,lt,eq,gt}=%b expected %b", name, cyc, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare the 16-bit instance against the model.
  task automatic tick();
    @(negedge clk);
    if (mon_en)
      check("seq16", {busy, done, lt, eq, gt}, {exp_busy, exp_done, m_lt, m_eq, m_gt});
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h9000, 16'h1FFF, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'h1233, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h1234, 16'h1324, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'hABCD, 16'hABCE, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    tick(); tick();
    check("reset16", {busy, done, lt, eq, gt}, 5'b00000);
    check("reset4", {busy4, done4, lt4, eq4, gt4}, 5'b00000);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Table vectors; operands are scrambled right after capture.
    for (int v = 0; v < 10; v++) begin
      start = 1'b1; a = vecs[v].a; b = vecs[v].b;
      tick();
      start = 1'b0; a = 16'($urandom); b = 16'($urandom);
      repeat (N + 2) tick();
      check($sformatf("vec%0d", v), {1'b0, 1'b0, lt, eq, gt},
            {1'b0, 1'b0, vecs[v].lt, vecs[v].eq, vecs[v].gt});
    end

    // start held high with operands changing every cycle.
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      a = 16'($urandom);
      case ($urandom_range(3))
        0:       b = a;
        1:       b = a ^ 16'h0001;
        2:       b = a ^ 16'h0100;
        default: b = 16'($urandom);
      endcase
      tick();
    end
    start = 1'b0;
    repeat (N + 2) tick();

    // Abort mid-RUN: rst in cycle 2, everything zero in cycle 3, no done afterwards.
    start = 1'b1; a = 16'h1234; b = 16'h1234;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort", {busy, done, lt, eq, gt}, 5'b00000);
    repeat (8) tick();

    // WIDTH=4 instance: single-cycle RUN.
    start4 = 1'b1; a4 = 4'h5; b4 = 4'h3;
    tick();
    start4 = 1'b0; a4 = 4'h0; b4 = 4'hF;
    check("w4_gt_c0", {busy4, done4, lt4, eq4, gt4}, 5'b10000);
    tick();
    check("w4_gt_c1", {busy4, done4, lt4, eq4, gt4}, 5'b11001);
    tick();
    check("w4_gt_c2", {busy4, done4, lt4, eq4, gt4}, 5'b00001);
    start4 = 1'b1; a4 = 4'hA; b4 = 4'hA;
    tick();
    start4 = 1'b0;
    check("w4_eq_c0", {busy4, done4, lt4, eq4, gt4}, 5'b10001);
    tick();
    check("w4_eq_c1", {busy4, done4, lt4, eq4, gt4}, 5'b11010);
    tick();
    check("w4_eq_c2", {busy4, done4, lt4, eq4, gt4}, 5'b00010);
    start4 = 1'b1; a4 = 4'h3; b4 = 4'h5;
    tick();
    start4 = 1'b0;
    tick();
    check("w4_lt_c1", {busy4, done4, lt4, eq4, gt4}, 5'b11100);
    tick();
    check("w4_lt_c2", {busy4, done4, lt4, eq4, gt4}, 5'b00100);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/compare_seq_ctrl.md
# compare_seq_ctrl

Sequential magnitude-comparison controller that time-shares a single `compare_4bit` slice to compare two unsigned WIDTH-bit operands nibble by nibble, MSB first. It sits between a requester issuing start pulses and the shared 4-bit comparator. It latches operands, walks the nibble index, combines the per-nibble lt/eq/gt into a final verdict, and reports it with a done pulse. This gives wide comparisons without replicating comparator hardware.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥4; N = WIDTH/4 nibbles
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, unsigned; captured on accepted start
- b  input  WIDTH  operand B, unsigned; captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; lt/eq/gt valid from this cycle
- lt  output  1  registered result, A < B
- eq  output  1  registered result, A == B
- gt  output  1  registered result, A > B

## Operation
- Clock is clk; reset is synchronous and active-high (rst).
- Reset: state=IDLE; busy=0, done=0, lt=eq=gt=0; index and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: when start=1, latch a/b into internal registers, set idx=N-1, go to RUN. When start=0, stay in IDLE.
- RUN: one comparator slice is fed a_reg[4*idx+3:4*idx] and b_reg[4*idx+3:4*idx].
  - Slice lt or gt: load lt/gt (eq=0) into the result registers, go to DONE.
  - Slice eq and idx=0: load eq=1, lt=gt=0, go to DONE.
  - Otherwise: idx ← idx-1, stay in RUN.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Results hold until the next decision; a new start does not clear them early. After the first done, exactly one of lt/eq/gt is high.
- start is ignored in RUN and DONE; there is no queuing. A held-high start re-triggers only after DONE→IDLE.
- Changes on a/b after capture have no effect on the operation in progress.
- rst at any cycle, including mid-RUN, aborts the operation: no done pulse, all outputs return to 0 the cycle after rst.
- Unsigned arithmetic only. idx width is clog2(N), minimum 1 bit. For WIDTH=4, RUN lasts exactly one cycle.

## Timing
- Let E0 be the rising edge where start is accepted. Cycle k is the cycle after edge Ek.
- busy=1 from cycle 0 through the DONE cycle inclusive.
- The decision occurs at the edge ending RUN cycle j-1; done=1 and results update in cycle j. j is the number of nibbles examined, 1..N.
- Start-to-done latency = j cycles:
  - 1 cycle minimum, on an MSB-nibble mismatch (early exit enabled).
  - N cycles maximum.
- busy=0 in cycle j+1. start is accepted at the edge ending cycle j+1, so back-to-back issue interval = j+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- COMPARE_SEQ_EARLY_EXIT_EN defined: RUN terminates at the first unequal nibble, giving variable latency 1..N.
- COMPARE_SEQ_EARLY_EXIT_EN undefined: RUN always examines all N nibbles, giving constant latency N.
  - The verdict of the first (most significant) unequal nibble is held in a sticky flag.
  - Less significant nibbles cannot override the sticky verdict.
  - eq=1 only if all nibbles compare equal.
  - Final results are identical to the enabled build; only timing differs.

## Test plan
- WIDTH=16, a=0x1234, b=0x1234, start pulse → busy cycles 0-4, done=1 in cycle 4, eq=1, lt=gt=0.
- a=0x9000, b=0x1FFF → gt=1, done in cycle 1 with macro; done in cycle 4 without macro, still gt=1.
- a=0x1233, b=0x1234 → lt=1, done in cycle 4 in both builds; a=0x0000, b=0xFFFF → lt=1.
- start held high continuously, with a/b changed every cycle while busy → one result per j+2 cycles, each matching operands captured at accept.
- rst=1 in cycle 2 of a 4-nibble operation → cycle 3: busy=0, done=0, lt=eq=gt=0; no done pulse ever for the aborted operation.
- WIDTH=4 instance, a=0x5, b=0x3 → done in cycle 1, gt=1; then a=b=0xA → eq=1.
